// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and FSM encoding for the memory copy engine.
package mem_pkg;
    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 18;
    typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;
endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: word-by-word forward memory copy, 3 cycles per word, with XOR checksum.
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_src, r_dst, r_addr;
    logic [ADDR_W:0]   r_rem;
    logic [DATA_W-1:0] r_checksum, r_wdata;
    logic              r_busy, r_done, r_rd, r_wr;

    assign busy         = r_busy;
    assign done         = r_done;
    assign checksum     = r_checksum;
    assign mem_addr     = r_addr;
    assign mem_read_en  = r_rd;
    assign mem_write_en = r_wr;
    assign mem_wdata    = r_wdata;

    // Outputs are computed for the state being entered, so they are registered alongside it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_rem      <= '0;
            r_addr     <= '0;
            r_checksum <= '0;
            r_wdata    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_src      <= src_addr;
                    r_dst      <= dst_addr;
                    r_rem      <= length;
                    r_checksum <= '0;
                    r_busy     <= 1'b1;
                    if (length == '0) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_READ;
                        r_rd    <= 1'b1;
                        r_addr  <= src_addr;
                    end
                end
                S_READ: r_state <= S_WAIT;
                S_WAIT: begin
                    r_checksum <= r_checksum ^ mem_rdata;
                    r_wdata    <= mem_rdata;
                    r_wr       <= 1'b1;
                    r_addr     <= r_dst;
                    r_state    <= S_WRITE;
                end
                S_WRITE: begin
                    r_src <= r_src + ADDR_W'(1);
                    r_dst <= r_dst + ADDR_W'(1);
                    r_rem <= r_rem - (ADDR_W+1)'(1);
                    if (r_rem == (ADDR_W+1)'(1)) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_READ;
                        r_rd    <= 1'b1;
                        r_addr  <= r_src + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: table-driven copies against a 1-cycle registered memory model with a strobe scoreboard.
module tb_mem_copy_engine;
    localparam int AW = 13;
    localparam int DW = 18;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [AW-1:0] src_addr = '0, dst_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy, done, mem_read_en, mem_write_en;
    logic [DW-1:0] checksum, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .length(length), .busy(busy), .done(done), .checksum(checksum), .mem_addr(mem_addr),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_read_en) mem_rdata <= mem[mem_addr];
        if (mem_write_en) mem[mem_addr] <= mem_wdata;
    end

    typedef struct {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
    typedef struct {logic [AW-1:0] s; logic [AW-1:0] d; logic [AW:0] n; logic [DW-1:0] cs; int lat;} vec_t;

    wr_t           wq[$];
    logic [AW-1:0] rq[$];
    int n_vec = 0, n_err = 0, n_done = 0, n_wr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return (DW'(a) * DW'(37)) ^ 18'h2B6C3;
    endfunction

    function automatic logic [DW-1:0] xr(input logic [AW-1:0] s, input int n);
        logic [DW-1:0] x = '0;
        for (int i = 0; i < n; i++) x ^= pat(s + AW'(i));
        return x;
    endfunction

    always @(posedge clk) begin
        assert (!(mem_read_en && mem_write_en)) else $error("read and write strobes together");
        assert (!(dut.r_state == mem_pkg::S_IDLE && busy)) else $error("busy high in IDLE");
    end

    always @(negedge clk) begin : mon
        logic [AW-1:0] ea;
        wr_t ew;
        if (!rst) begin
            if (done) n_done++;
            if (mem_read_en) begin
                if (rq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected read: addr %0h expected none", mem_addr);
                end else begin
                    ea = rq.pop_front();
                    check("read addr", mem_addr, ea);
                end
            end
            if (mem_write_en) begin
                n_wr++;
                if (wq.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected write: addr %0h expected none", mem_addr);
                end else begin
                    ew = wq.pop_front();
                    check("write addr", mem_addr, ew.a);
                    check("write data", mem_wdata, ew.d);
                end
            end
            if (!mem_read_en && !mem_write_en) check("idle addr", mem_addr, 0);
            if (!mem_write_en) check("idle wdata", mem_wdata, 0);
        end
    end

    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] n,
                            input logic [DW-1:0] exp_cs, input int exp_lat, input bit inject);
        int lat, d0, w0;
        logic [DW-1:0] exp_d[$];
        logic [AW-1:0] a;
        for (int i = 0; i < int'(n); i++) begin
            a = s + AW'(i);
            rq.push_back(a);
            exp_d.push_back(mem[a]);
            wq.push_back('{d + AW'(i), mem[a]});
        end
        d0 = n_done;
        w0 = n_wr;
        start = 1'b1; src_addr = s; dst_addr = d; length = n;
        @(negedge clk);
        start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        lat = 1;
        check("busy after start", busy, 1);
        while (!done && lat < 3 * int'(n) + 20) begin
            @(negedge clk);
            lat++;
            if (inject && lat == 2) begin
                start = 1'b1; src_addr = 13'h0B00; dst_addr = 13'h0C00; length = 14'd5;
            end else begin
                start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
            end
        end
        check("done latency", lat, exp_lat);
        check("checksum at done", checksum, exp_cs);
        @(negedge clk);
        check("busy after done", busy, 0);
        check("checksum held", checksum, exp_cs);
        check("done pulses", n_done - d0, 1);
        check("write count", n_wr - w0, n);
        check("reads pending", rq.size(), 0);
        check("writes pending", wq.size(), 0);
        for (int i = 0; i < int'(n); i++) check("dst word", mem[d + AW'(i)], exp_d[i]);
    endtask

    vec_t tbl[5];

    initial begin
        int d0, w0;
        logic [DW-1:0] old1;
        for (int i = 0; i < (1 << AW); i++) mem[i] = pat(AW'(i));
        mem[16] = 18'h00001; mem[17] = 18'h00002; mem[18] = 18'h00004; mem[19] = 18'h3FFFF;
        tbl[0] = '{13'h0010, 13'h0100, 14'd4, 18'h3FFF8, 13};
        tbl[1] = '{13'h0020, 13'h0200, 14'd0, 18'h0, 1};
        tbl[2] = '{13'd8190, 13'd4, 14'd4, xr(13'd8190, 4), 13};
        tbl[3] = '{13'h0500, 13'h0600, 14'd1, xr(13'h0500, 1), 4};
        tbl[4] = '{13'h0700, 13'h0800, 14'd7, xr(13'h0700, 7), 22};

        repeat (3) @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset checksum", checksum, 0);
        check("reset strobes", {mem_read_en, mem_write_en}, 0);
        check("reset addr", mem_addr, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            run_copy(tbl[k].s, tbl[k].d, tbl[k].n, tbl[k].cs, tbl[k].lat, 1'b0);
            @(negedge clk);
        end

        // A second start two cycles into a copy must be ignored.
        run_copy(13'h0900, 13'h0A00, 14'd3, xr(13'h0900, 3), 10, 1'b1);
        @(negedge clk);

        // Reset during the WAIT before the second write aborts after one word.
        old1 = mem[13'h0E01];
        rq.push_back(13'h0D00); rq.push_back(13'h0D01);
        wq.push_back('{13'h0E00, pat(13'h0D00)});
        d0 = n_done;
        w0 = n_wr;
        start = 1'b1; src_addr = 13'h0D00; dst_addr = 13'h0E00; length = 14'd5;
        @(negedge clk);
        start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        rq.delete();
        @(negedge clk);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        check("abort strobes", {mem_read_en, mem_write_en}, 0);
        check("abort addr", mem_addr, 0);
        check("abort wdata", mem_wdata, 0);
        check("abort checksum", checksum, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort no done", n_done - d0, 0);
        check("abort writes", n_wr - w0, 1);
        check("abort word0", mem[13'h0E00], pat(13'h0D00));
        check("abort word1", mem[13'h0E01], old1);
        check("abort write queue", wq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 Parameters (name, default, meaning): ADDR_W, 13, memory address width; DATA_W, 18, memory word width.
REQ-002 clk  input  1  clock; all logic SHALL update on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin a copy; SHALL be sampled only in IDLE.
REQ-005 src_addr  input  ADDR_W  first source word address; SHALL be latched on an accepted start.
REQ-006 dst_addr  input  ADDR_W  first destination word address; SHALL be latched on an accepted start.
REQ-007 length  input  ADDR_W+1  word count, 0..8192; SHALL be latched on an accepted start.
REQ-008 busy  output  1  high from the cycle after an accepted start until DONE inclusive.
REQ-009 done  output  1  one-cycle pulse on copy completion.
REQ-010 checksum  output  DATA_W  XOR of all words copied by the last copy; SHALL remain stable until the next accepted start.
REQ-011 mem_addr  output  ADDR_W  address to memory.
REQ-012 mem_read_en / mem_write_en  output  1 each  memory strobes.
REQ-013 mem_wdata  output  DATA_W  write data to memory.
REQ-014 mem_rdata  input  DATA_W  registered memory read data, valid the cycle after a read strobe.

Function
REQ-015 FSM states SHALL be IDLE, READ, WAIT, WRITE, DONE.
REQ-016 IDLE: start=1 and length>0 -> READ; start=1 and length=0 -> DONE with no memory strobe; otherwise stay.
REQ-017 READ: mem_read_en=1, mem_write_en=0, mem_addr=current source pointer, for exactly one cycle -> WAIT.
REQ-018 WAIT: no strobes; mem_rdata SHALL be captured into a data register and XORed into checksum at the end of this cycle -> WRITE.
REQ-019 WRITE: mem_write_en=1, mem_read_en=0, mem_addr=current destination pointer, mem_wdata=data register, for one cycle; both pointers SHALL increment and the remaining count SHALL decrement; remaining=0 after decrement -> DONE, else -> READ.
REQ-020 DONE: done=1 for one cycle -> IDLE.
REQ-021 Throughput SHALL be exactly 3 cycles per word; total latency from accepted start to done = 3*length+1 cycles (1 cycle for length=0).
REQ-022 mem_read_en and mem_write_en SHALL never be high in the same cycle.
REQ-023 Pointers SHALL wrap modulo 2^ADDR_W (8191+1 -> 0) without error.
REQ-024 Overlapping regions SHALL be copied strictly forward, word by word; no overlap detection is performed.
REQ-025 start while busy SHALL be ignored, with no effect on the copy in progress.
REQ-026 checksum SHALL clear to 0 on an accepted start; for length=0 it SHALL read 0 at done.
REQ-027 mem_addr and mem_wdata SHALL be 0 in all states except READ/WRITE.

Reset
REQ-028 rst SHALL force IDLE and clear busy, done, checksum, mem_addr, mem_read_en, mem_write_en, mem_wdata, and all pointers and counters to 0.
REQ-029 rst asserted mid-copy SHALL abort within the same edge; words already written SHALL remain, no further strobes SHALL be issued, and done SHALL NOT pulse.

Structure
REQ-030 ADDR_W/DATA_W defaults and the state encoding SHALL live in shared package mem_pkg.
REQ-031 The block SHALL be a single module with no sub-module; all outputs SHALL be registered.

Verification
REQ-032 Bench SHALL use a behavioural memory model with a 1-cycle registered read.
REQ-033 Preload src 0x0010..0x0013 = 18'h00001, 18'h00002, 18'h00004, 18'h3FFFF; copy to 0x0100 with length=4 -> dst holds identical words, done at cycle 13 after start, checksum=18'h3FFF8.
REQ-034 length=0 -> done one cycle after start, zero strobes, checksum=0.
REQ-035 src=8190, dst=4, length=4 -> reads at 8190, 8191, 0, 1 in that order.
REQ-036 Pulse start again 2 cycles into a length=3 copy -> it is ignored, exactly 3 writes occur, one done pulse.
REQ-037 Assert rst on the second WRITE of a length=5 copy -> exactly 1 word written, all outputs 0 the next cycle, no done.
REQ-038 Assertion for the full run: read and write strobes never high together; busy is low whenever the FSM is in IDLE.
